// File: rtl/pkt_data_gen.sv
// pkt_data_gen
// AXI-Stream test-pattern packet generator. A run started by `start` emits
// cfg_pkt_count packets (0 = unlimited) of cfg_pkt_beats beats (0 = 1 beat).
// Each beat carries a 16-bit per-channel incrementing pattern replicated
// across TDATA. A `stop` pulse ends the run on the next packet boundary.
//
// Optional feature macro: PKT_DATA_GEN_SEQNUM_EN
//   defined   -> first beat of each packet carries the packet sequence
//                number in TDATA[31:0]; the pattern still advances.
//   undefined -> every beat is the pure replicated pattern.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, stop         run control pulses
//   cfg_pkt_beats       beats per packet, sampled only at the start edge
//   cfg_pkt_count       packets per run, sampled only at the start edge
//   AXIS_OUT_*          AXI-Stream master (TDATA/TKEEP/TLAST/TVALID/TREADY)
//   busy                high while a run is active or draining
//   pkts_sent           packets completed since the last start (saturating)
module pkt_data_gen #(
    parameter int DW      = 512,
    parameter int CHANNEL = 0,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_pkt_beats,
    input  logic [31:0]       cfg_pkt_count,
    output logic [DW-1:0]     AXIS_OUT_TDATA,
    output logic [DW/8-1:0]   AXIS_OUT_TKEEP,
    output logic              AXIS_OUT_TLAST,
    output logic              AXIS_OUT_TVALID,
    input  logic              AXIS_OUT_TREADY,
    output logic              busy,
    output logic [31:0]       pkts_sent
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0]  CH8  = 8'(CHANNEL);
    localparam logic [15:0] SEED = {CH8, CH8};

    state_t             r_state;
    logic [LEN_W-1:0]   r_beats_m1;
    logic [31:0]        r_count;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic [31:0]        r_pkts_sent;
    logic [15:0]        r_pattern;
    logic               r_tvalid;
    logic               r_tlast;
    logic [DW-1:0]      r_tdata;
    logic               r_busy;

    state_t             w_nxt_state;
    logic [LEN_W-1:0]   w_nxt_beats_m1;
    logic [31:0]        w_nxt_count;
    logic [LEN_W-1:0]   w_nxt_beat_cnt;
    logic [31:0]        w_nxt_pkts;
    logic [15:0]        w_nxt_pattern;
    logic               w_nxt_tvalid;
    logic               w_nxt_tlast;
    logic [DW-1:0]      w_nxt_tdata;
    logic [DW-1:0]      w_rep;
    logic               w_hs;
    logic               w_last_hs;
    logic [31:0]        w_pkts_inc;

    assign w_hs       = r_tvalid & AXIS_OUT_TREADY;
    assign w_last_hs  = w_hs & r_tlast;
    assign w_pkts_inc = (r_pkts_sent == 32'hFFFF_FFFF) ? r_pkts_sent : (r_pkts_sent + 32'd1);

    // Next-state, counters and next registered output values.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_beats_m1 = r_beats_m1;
        w_nxt_count    = r_count;
        w_nxt_beat_cnt = r_beat_cnt;
        w_nxt_pkts     = r_pkts_sent;
        w_nxt_pattern  = r_pattern;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_state    = S_RUN;
                    // A zero beat count is treated as a single-beat packet.
                    w_nxt_beats_m1 = (cfg_pkt_beats == {LEN_W{1'b0}}) ? {LEN_W{1'b0}}
                                                                      : (cfg_pkt_beats - {{(LEN_W-1){1'b0}}, 1'b1});
                    w_nxt_count    = cfg_pkt_count;
                    w_nxt_beat_cnt = {LEN_W{1'b0}};
                    w_nxt_pkts     = 32'd0;
                    w_nxt_pattern  = SEED;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_RUN, S_DRAIN: begin
                if (w_hs) begin
                    w_nxt_pattern = r_pattern + 16'd1;
                    if (r_tlast) begin
                        w_nxt_beat_cnt = {LEN_W{1'b0}};
                        w_nxt_pkts     = w_pkts_inc;
                    end else begin
                        w_nxt_beat_cnt = r_beat_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_nxt_pattern = r_pattern;
                end

                if (r_state == S_RUN) begin
                    // Stop on a boundary handshake ends the run at once; a stop
                    // mid-packet waits in DRAIN for the packet to complete.
                    if (w_last_hs && (stop || ((r_count != 32'd0) && (w_pkts_inc == r_count)))) begin
                        w_nxt_state = S_IDLE;
                    end else if (stop) begin
                        w_nxt_state = S_DRAIN;
                    end else begin
                        w_nxt_state = S_RUN;
                    end
                end else begin
                    if (w_last_hs) begin
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_state = S_DRAIN;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they can be registered
        // without adding a cycle of latency. During a stall every input to
        // these terms is unchanged, so TDATA/TLAST hold.
        w_nxt_tvalid = (w_nxt_state != S_IDLE);
        w_nxt_tlast  = w_nxt_tvalid && (w_nxt_beat_cnt == w_nxt_beats_m1);
        w_rep        = {(DW/16){w_nxt_pattern}};
`ifdef PKT_DATA_GEN_SEQNUM_EN
        if (w_nxt_tvalid && (w_nxt_beat_cnt == {LEN_W{1'b0}})) begin
            w_nxt_tdata = {w_rep[DW-1:32], w_nxt_pkts};
        end else if (w_nxt_tvalid) begin
            w_nxt_tdata = w_rep;
        end else begin
            w_nxt_tdata = {DW{1'b0}};
        end
`else
        if (w_nxt_tvalid) begin
            w_nxt_tdata = w_rep;
        end else begin
            w_nxt_tdata = {DW{1'b0}};
        end
`endif
    end

    // State, counters and registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_beats_m1  <= {LEN_W{1'b0}};
            r_count     <= 32'd0;
            r_beat_cnt  <= {LEN_W{1'b0}};
            r_pkts_sent <= 32'd0;
            r_pattern   <= 16'd0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= {DW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_beats_m1  <= w_nxt_beats_m1;
            r_count     <= w_nxt_count;
            r_beat_cnt  <= w_nxt_beat_cnt;
            r_pkts_sent <= w_nxt_pkts;
            r_pattern   <= w_nxt_pattern;
            r_tvalid    <= w_nxt_tvalid;
            r_tlast     <= w_nxt_tlast;
            r_tdata     <= w_nxt_tdata;
            r_busy      <= (w_nxt_state != S_IDLE);
        end
    end

    assign AXIS_OUT_TDATA  = r_tdata;
    assign AXIS_OUT_TKEEP  = {(DW/8){1'b1}};
    assign AXIS_OUT_TLAST  = r_tlast;
    assign AXIS_OUT_TVALID = r_tvalid;
    assign busy            = r_busy;
    assign pkts_sent       = r_pkts_sent;

endmodule

// File: tb/tb_pkt_data_gen.sv
// Testbench for pkt_data_gen: randomized ready/config stimulus compared
// against a beat-sequence model built from the packet rules.
module tb_pkt_data_gen;

    localparam int DWA = 512;
    localparam int DWB = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             a_start, a_stop, a_ready;
    logic [7:0]       a_beats;
    logic [31:0]      a_count;
    logic [DWA-1:0]   a_tdata;
    logic [DWA/8-1:0] a_tkeep;
    logic             a_tlast, a_tvalid, a_busy;
    logic [31:0]      a_pkts;

    logic             b_start, b_stop, b_ready;
    logic [7:0]       b_beats;
    logic [31:0]      b_count;
    logic [DWB-1:0]   b_tdata;
    logic [DWB/8-1:0] b_tkeep;
    logic             b_tlast, b_tvalid, b_busy;
    logic [31:0]      b_pkts;

    pkt_data_gen #(.DW(DWA), .CHANNEL(3), .LEN_W(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop),
        .cfg_pkt_beats(a_beats), .cfg_pkt_count(a_count),
        .AXIS_OUT_TDATA(a_tdata), .AXIS_OUT_TKEEP(a_tkeep), .AXIS_OUT_TLAST(a_tlast),
        .AXIS_OUT_TVALID(a_tvalid), .AXIS_OUT_TREADY(a_ready),
        .busy(a_busy), .pkts_sent(a_pkts));

    pkt_data_gen #(.DW(DWB), .CHANNEL(255), .LEN_W(8)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
        .cfg_pkt_beats(b_beats), .cfg_pkt_count(b_count),
        .AXIS_OUT_TDATA(b_tdata), .AXIS_OUT_TKEEP(b_tkeep), .AXIS_OUT_TLAST(b_tlast),
        .AXIS_OUT_TVALID(b_tvalid), .AXIS_OUT_TREADY(b_ready),
        .busy(b_busy), .pkts_sent(b_pkts));

    int n_cmp = 0;
    int n_err = 0;

    logic [DWA-1:0] obs_d[$];
    logic           obs_l[$];
    int stall_errs, first_hs, last_hs, end_cyc;
    bit timed_out;

    // Expected beat k of a run: pattern seed+k, optionally with seq number.
    function automatic logic [DWA-1:0] exp_a(input logic [15:0] seed, input int k, input int be);
        logic [15:0]    p;
        logic [DWA-1:0] d;
        p = seed + 16'(k);
        d = {(DWA/16){p}};
`ifdef PKT_DATA_GEN_SEQNUM_EN
        if ((k % be) == 0) d[31:0] = 32'(k / be);
`endif
        return d;
    endfunction

    task automatic do_start(input logic [7:0] beats, input logic [31:0] cnt);
        a_beats = beats; a_count = cnt; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_beats = 8'($urandom);
        a_count = $urandom;
    endtask

    // Drives random ready and records every handshaked beat until busy drops.
    task automatic collect(input int budget, input int rdy_pct, input int stop_beat);
        logic [DWA-1:0] hd;
        logic hl;
        bit holding;
        int nb;
        holding = 1'b0; nb = 0; hd = '0; hl = 1'b0;
        obs_d.delete(); obs_l.delete();
        stall_errs = 0; timed_out = 1'b1; first_hs = -1; last_hs = -1; end_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            if (!a_busy) begin
                end_cyc = c; timed_out = 1'b0;
                break;
            end
            if (holding && (a_tdata !== hd || a_tlast !== hl || a_tvalid !== 1'b1)) stall_errs++;
            a_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            a_stop  = 1'b0;
            if (a_tvalid && a_ready) begin
                obs_d.push_back(a_tdata); obs_l.push_back(a_tlast); nb++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                if (nb == stop_beat) a_stop = 1'b1;
            end
            holding = a_tvalid && !a_ready; hd = a_tdata; hl = a_tlast;
            @(negedge clk);
        end
        a_ready = 1'b0; a_stop = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl valid=%b last=%b busy=%b want 0 0 0", a_tvalid, a_tlast, a_busy);
        end
        n_cmp++;
        if (a_tdata !== '0 || a_pkts !== 32'd0) begin
            n_err++; $display("FAIL reset_data tdata=%h pkts=%0d want 0 0", a_tdata, a_pkts);
        end
        n_cmp++;
        if (a_tkeep !== {(DWA/8){1'b1}} || b_tkeep !== 4'hF) begin
            n_err++; $display("FAIL tkeep a=%h b=%h want all ones", a_tkeep, b_tkeep);
        end
    endtask

    task automatic check_run(input string nm, input int nexp, input int be, input logic [31:0] pexp);
        n_cmp++;
        if (timed_out) begin
            n_err++; $display("FAIL %s_timeout busy never dropped", nm);
        end
        n_cmp++;
        if (obs_d.size() != nexp) begin
            n_err++; $display("FAIL %s_beats got=%0d want=%0d", nm, obs_d.size(), nexp);
        end
        for (int k = 0; k < nexp && k < obs_d.size(); k++) begin
            n_cmp++;
            if (obs_d[k] !== exp_a(16'h0303, k, be) || obs_l[k] !== ((k % be) == be - 1)) begin
                n_err++;
                $display("FAIL %s_beat%0d data=%h last=%b want data=%h last=%b", nm, k,
                         obs_d[k][31:0], obs_l[k], exp_a(16'h0303, k, be)[31:0], (k % be) == be - 1);
            end
        end
        n_cmp++;
        if (a_pkts !== pexp || a_tvalid !== 1'b0) begin
            n_err++; $display("FAIL %s_end pkts=%0d valid=%b want %0d 0", nm, a_pkts, a_tvalid, pexp);
        end
        n_cmp++;
        if (end_cyc != last_hs + 1) begin
            n_err++; $display("FAIL %s_busy_drop cycle=%0d want=%0d", nm, end_cyc, last_hs + 1);
        end
    endtask

    task automatic test_basic;
        do_start(8'd8, 32'd2);
        n_cmp++;
        if (a_busy !== 1'b1 || a_tvalid !== 1'b1) begin
            n_err++; $display("FAIL start_latency busy=%b valid=%b want 1 1", a_busy, a_tvalid);
        end
        collect(200, 100, 0);
        check_run("basic", 16, 8, 32'd2);
        n_cmp++;
        if (last_hs - first_hs != 15) begin
            n_err++; $display("FAIL basic_bubbles span=%0d want 15", last_hs - first_hs);
        end
    endtask

    task automatic test_backpressure;
        int b, be, cnt;
        do_start(8'd5, 32'd4);
        collect(2000, 50, 0);
        check_run("bp", 20, 5, 32'd4);
        n_cmp++;
        if (stall_errs != 0) begin
            n_err++; $display("FAIL bp_stall unstable=%0d want 0", stall_errs);
        end
        for (int r = 0; r < 3; r++) begin
            b = int'($urandom_range(0, 12)); be = (b == 0) ? 1 : b; cnt = int'($urandom_range(1, 4));
            do_start(8'(b), 32'(cnt));
            collect(3000, 40, 0);
            check_run("bprand", be * cnt, be, 32'(cnt));
            n_cmp++;
            if (stall_errs != 0) begin
                n_err++; $display("FAIL bprand_stall unstable=%0d want 0", stall_errs);
            end
        end
    endtask

    task automatic test_stop;
        int be, sb;
        do_start(8'd6, 32'd0);
        collect(200, 100, 3);
        check_run("stop_mid", 6, 6, 32'd1);
        do_start(8'd6, 32'd0);
        collect(200, 100, 6);
        check_run("stop_last", 6, 6, 32'd1);
        be = int'($urandom_range(1, 10)); sb = be + int'($urandom_range(1, be));
        do_start(8'(be), 32'd0);
        collect(2000, 70, sb);
        check_run("stop_rand", 2 * be, be, 32'd2);
        // stop while idle must be ignored
        a_stop = 1'b1; @(negedge clk); a_stop = 1'b0; @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_tvalid !== 1'b0) begin
            n_err++; $display("FAIL stop_idle busy=%b valid=%b want 0 0", a_busy, a_tvalid);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] p;
        logic [DWB-1:0] e;
        int k;
        k = 0;
        b_beats = 8'd3; b_count = 32'd2; b_start = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 50 && b_busy; c++) begin
            if (b_tvalid) begin
                p = 16'hFFFF + 16'(k);
                e = {2{p}};
`ifdef PKT_DATA_GEN_SEQNUM_EN
                if ((k % 3) == 0) e = 32'(k / 3);
`endif
                n_cmp++;
                if (b_tdata !== e || b_tlast !== ((k % 3) == 2)) begin
                    n_err++; $display("FAIL wrap_beat%0d data=%h last=%b want %h %b", k, b_tdata, b_tlast, e, (k % 3) == 2);
                end
                k++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (k != 6 || b_busy !== 1'b0 || b_pkts !== 32'd2) begin
            n_err++; $display("FAIL wrap_end beats=%0d busy=%b pkts=%0d want 6 0 2", k, b_busy, b_pkts);
        end
        b_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_start(8'd4, 32'd0);
        a_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (a_pkts !== 32'd1 || a_tvalid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre pkts=%0d valid=%b want 1 1", a_pkts, a_tvalid);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_pkts !== 32'd0 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid valid=%b last=%b pkts=%0d busy=%b want 0 0 0 0", a_tvalid, a_tlast, a_pkts, a_busy);
        end
        a_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_start(8'd0, 32'd3);
        collect(200, 100, 0);
        check_run("single", 3, 1, 32'd3);
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0; a_beats = 8'd0; a_count = 32'd0;
        b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0; b_beats = 8'd0; b_count = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_backpressure();
        test_stop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
